// File: rtl/twi_slave.sv
// I2C/TWI target: synchronises and filters SCL/SDA, detects START/STOP, matches a 7-bit
// address and moves bytes between the bus and a local register space with an auto-incrementing pointer.

module twi_slave_filt #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);
  localparam int CW = $clog2(FILT + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The filtered level flips only after FILT consecutive synchronised samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module twi_slave #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         FILT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oen,
  output logic [7:0] reg_adr,
  output logic       wr_stb,
  output logic [7:0] wr_dat,
  input  logic [7:0] rd_dat,
  output logic       rd_stb,
  output logic       busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADR_ACK, PTR, PTR_ACK, WDATA, WD_ACK, RDATA, RD_ACKCHK, IGNORE
  } state_t;

  logic   scl_f, sda_f, scl_q, sda_q;
  logic   scl_rise, scl_fall, start_c, stop_c;
  state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] rx, rx_n, tx, tx_n;
  logic [7:0] reg_adr_n, wr_dat_n;
  logic       rw, rw_n, master_ack, master_ack_n;
  logic       sda_oen_n, wr_stb_n, rd_stb_n, busy_n;

  twi_slave_filt #(.FILT(FILT)) u_scl_filt (.clk(clk), .rst(rst), .pin(scl), .level(scl_f));
  twi_slave_filt #(.FILT(FILT)) u_sda_filt (.clk(clk), .rst(rst), .pin(sda), .level(sda_f));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      rw         <= 1'b0;
      master_ack <= 1'b1;
      sda_oen    <= 1'b1;
      reg_adr    <= '0;
      wr_stb     <= 1'b0;
      wr_dat     <= '0;
      rd_stb     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      rx         <= rx_n;
      tx         <= tx_n;
      rw         <= rw_n;
      master_ack <= master_ack_n;
      sda_oen    <= sda_oen_n;
      reg_adr    <= reg_adr_n;
      wr_stb     <= wr_stb_n;
      wr_dat     <= wr_dat_n;
      rd_stb     <= rd_stb_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    rx_n         = rx;
    tx_n         = tx;
    rw_n         = rw;
    master_ack_n = master_ack;
    sda_oen_n    = sda_oen;
    reg_adr_n    = reg_adr;
    wr_stb_n     = 1'b0;
    wr_dat_n     = wr_dat;
    rd_stb_n     = 1'b0;
    busy_n       = busy;

    // Strobe follow-up: bump the pointer, and on a fetch latch RD_DAT and put its MSB on the bus.
    if (wr_stb || rd_stb) reg_adr_n = reg_adr + 8'd1;
    if (rd_stb) begin
      tx_n      = rd_dat;
      sda_oen_n = rd_dat[7];
    end

    if (start_c) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oen_n = 1'b1;
      busy_n    = 1'b1;
    end else if (stop_c) begin
      state_n   = IDLE;
      sda_oen_n = 1'b1;
      busy_n    = 1'b0;
    end else begin
      if (scl_rise) begin
        if (state inside {ADDR, PTR, WDATA}) begin
          rx_n      = {rx[6:0], sda_f};
          bit_cnt_n = bit_cnt + 4'd1;
        end
        if (state == RD_ACKCHK) master_ack_n = sda_f;
      end

      if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            if (rx[7:1] == SLV_ADDR) begin
              sda_oen_n = 1'b0;
              rw_n      = rx[0];
              state_n   = ADR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
          ADR_ACK: begin
            sda_oen_n = 1'b1;
            bit_cnt_n = '0;
            if (rw) begin
              rd_stb_n = 1'b1;
              state_n  = RDATA;
            end else begin
              state_n = PTR;
            end
          end
          PTR: if (bit_cnt == 4'd8) begin
            reg_adr_n = rx;
            sda_oen_n = 1'b0;
            state_n   = PTR_ACK;
          end
          PTR_ACK, WD_ACK: begin
            sda_oen_n = 1'b1;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
          WDATA: if (bit_cnt == 4'd8) begin
            wr_stb_n  = 1'b1;
            wr_dat_n  = rx;
            sda_oen_n = 1'b0;
            state_n   = WD_ACK;
          end
          // bit_cnt counts bits already sent after the MSB; the eighth fall hands SDA to the master.
          RDATA: if (bit_cnt == 4'd7) begin
            sda_oen_n = 1'b1;
            state_n   = RD_ACKCHK;
          end else begin
            tx_n      = {tx[6:0], 1'b0};
            sda_oen_n = tx[6];
            bit_cnt_n = bit_cnt + 4'd1;
          end
          RD_ACKCHK: begin
            if (!master_ack) begin
              rd_stb_n  = 1'b1;
              bit_cnt_n = '0;
              state_n   = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
